// File: rtl/cpu_pkg.sv
// Shared fetch-unit types and constants: widths, PC step, alignment mask
// and the sequencer state encoding.
package cpu_pkg;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;

  localparam logic [ADDR_W-1:0] PC_STEP = 64'd4;

  // Instructions are word aligned; any set bit under this mask marks a bad target.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = 64'h3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    REDIR = 3'd4,
    FAULT = 3'd5
  } ifetch_state_t;

  function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
    return |(addr & ALIGN_MASK);
  endfunction

endpackage

// File: rtl/ifetch_ctrl_if.sv
// Bundle of the fetch sequencer's PC-register, instruction-memory, decode
// and redirect signals; master is the sequencer, slave is its surroundings.
interface ifetch_ctrl_if;
  import cpu_pkg::*;

  logic [ADDR_W-1:0]  pc_cur;
  logic               pc_write;
  logic [ADDR_W-1:0]  pc_next;

  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  logic               if_valid;
  logic               if_ready;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;

  logic               br_valid;
  logic [ADDR_W-1:0]  br_target;
  logic               fetch_fault;

  modport master (
    input  pc_cur,
    output pc_write, pc_next,
    output imem_req_valid, imem_addr,
    input  imem_req_ready,
    input  imem_rvalid, imem_rdata,
    output if_valid, if_instr, if_pc,
    input  if_ready,
    input  br_valid, br_target,
    output fetch_fault
  );

  modport slave (
    output pc_cur,
    input  pc_write, pc_next,
    input  imem_req_valid, imem_addr,
    output imem_req_ready,
    output imem_rvalid, imem_rdata,
    input  if_valid, if_instr, if_pc,
    output if_ready,
    output br_valid, br_target,
    input  fetch_fault
  );

endinterface

// File: rtl/ifetch_ctrl.sv
// Fetch sequencer: one outstanding instruction-memory request, a one-entry
// holding register toward decode, and branch redirect with squash.
module ifetch_ctrl
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  ifetch_ctrl_if.master bus
);

  ifetch_state_t      state_reg;
  logic               squash_reg;
  logic               if_valid_reg;
  logic               fault_reg;
  logic [INSTR_W-1:0] if_instr_reg;
  logic [ADDR_W-1:0]  if_pc_reg;

  logic               br_live;
  logic               br_bad;
  logic               br_ok;
  logic               req_valid;
  logic               req_fire;
  logic               pc_wr;
  logic [ADDR_W-1:0]  pc_nx;

  // Redirects are ignored while starting up and once faulted.
  assign br_live   = bus.br_valid && (state_reg != IDLE) && (state_reg != FAULT);
  assign br_bad    = br_live && is_misaligned(bus.br_target);
  assign br_ok     = br_live && !br_bad;
  assign req_valid = (state_reg == REQ);
  assign req_fire  = req_valid && bus.imem_req_ready;

  always_comb begin
    pc_wr = 1'b0;
    pc_nx = '0;
    if (br_ok) begin
      pc_wr = 1'b1;
      pc_nx = bus.br_target;
    end else if (req_fire && !br_bad) begin
      pc_wr = 1'b1;
      pc_nx = bus.pc_cur + PC_STEP;
    end
  end

  assign bus.pc_write       = pc_wr;
  assign bus.pc_next        = pc_nx;
  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = req_valid ? bus.pc_cur : '0;
  assign bus.if_valid       = if_valid_reg;
  assign bus.if_instr       = if_instr_reg;
  assign bus.if_pc          = if_pc_reg;
  assign bus.fetch_fault    = fault_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      squash_reg   <= 1'b0;
      if_valid_reg <= 1'b0;
      fault_reg    <= 1'b0;
      if_instr_reg <= '0;
      if_pc_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: state_reg <= REQ;

        FAULT: state_reg <= FAULT;

        REQ, WAIT, HOLD, REDIR: begin
          if (br_bad) begin
            fault_reg    <= 1'b1;
            if_valid_reg <= 1'b0;
            state_reg    <= FAULT;
          end else begin
            case (state_reg)
              REQ: begin
                if (req_fire) begin
                  if_pc_reg <= bus.pc_cur;
                  state_reg <= WAIT;
                  // The accepted request is for the pre-redirect PC; its response must die.
                  if (br_ok) squash_reg <= 1'b1;
                end else if (br_ok) begin
                  state_reg <= REDIR;
                end
              end

              WAIT: begin
                if (br_ok) begin
                  if (bus.imem_rvalid) begin
                    squash_reg <= 1'b0;
                    state_reg  <= REDIR;
                  end else begin
                    squash_reg <= 1'b1;
                  end
                end else if (bus.imem_rvalid) begin
                  if (squash_reg) begin
                    squash_reg <= 1'b0;
                    state_reg  <= REQ;
                  end else begin
                    if_instr_reg <= bus.imem_rdata;
                    if_valid_reg <= 1'b1;
                    state_reg    <= HOLD;
                  end
                end
              end

              HOLD: begin
                if (br_ok || bus.if_ready) begin
                  if_valid_reg <= 1'b0;
                  state_reg    <= br_ok ? REDIR : REQ;
                end
              end

              // A redirect during the bubble needs another bubble for pc_cur to settle.
              default: state_reg <= br_ok ? REDIR : REQ;
            endcase
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
